// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among four requesters.
// Optional macro REGFILE_ARB_XZR_FILTER_EN: grants to address all-ones (XZR) are acknowledged but not written.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     gnt,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data,
    output logic [1:0]          wr_src
);

    logic [1:0]      ptr;
    logic [NREQ-1:0] elig;
    logic [1:0]      cand;
    logic [1:0]      win;
    logic            found;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // A requester granted last cycle is masked so its payload can be refreshed first.
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + 2'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_addr = req_addr[int'(win)*AW +: AW];
        win_data = req_data[int'(win)*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            gnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
        end else if (found) begin
            ptr     <= win + 2'd1;
            gnt     <= NREQ'(1) << win;
`ifdef REGFILE_ARB_XZR_FILTER_EN
            wr_en   <= (win_addr != {AW{1'b1}});
`else
            wr_en   <= 1'b1;
`endif
            wr_addr <= win_addr;
            wr_data <= win_data;
            wr_src  <= win;
        end else begin
            // Idle: payload outputs keep their last values.
            gnt     <= '0;
            wr_en   <= 1'b0;
        end
    end

endmodule
